range_window_ctrl: RTL and testbench
====================================

// Module: range_window_ctrl
// PURPOSE
//  Sequencer for the range-finder datapath in my_chip. Accepts a valid/ready sample stream and
//  cuts it into fixed windows of WIN_LEN samples, driving rf_go/rf_finish/rf_data so every window
//  is one legal range-finder pass. Captures rf_range/rf_error after each pass and offers them on
//  a valid/ready result port. The range finder itself stays a separate instance next to this block.
// PARAMETERS
//  WIDTH    10  sample and range width
//  WIN_LEN  8   samples per window; legal range 2..1023
//  RF_LAT   1   cycles from the rf_finish cycle until rf_range/rf_error are valid; legal range 1..7
// PORTS
//  clock      in   1      single clock, all state on posedge
//  reset      in   1      synchronous, active-high
//  in_data    in   WIDTH  sample
//  in_valid   in   1      sample present
//  in_ready   out  1      sample accepted when in_valid & in_ready
//  abort      in   1      drop current window, return to IDLE
//  rf_data    out  WIDTH  to range finder data_in
//  rf_go      out  1      to range finder go (1-cycle pulse)
//  rf_finish  out  1      to range finder finish (1-cycle pulse)
//  rf_range   in   WIDTH  from range finder range
//  rf_error   in   1      from range finder debug_error
//  out_range  out  WIDTH  captured range (max-min of window)
//  out_err    out  1      captured rf_error for that window
//  out_valid  out  1      result held until out_ready
//  out_ready  in   1      result consumed when out_valid & out_ready
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; cnt=0; rf_data=0; rf_go=rf_finish=0; out_valid=0; out_range=0; out_err=0.
//  The range finder samples rf_data every cycle between go and finish inclusive. A repeated sample
//  leaves max-min unchanged, so during input gaps rf_data holds the last accepted sample.
//  States: IDLE, RUN, WAIT, HOLD.
//   IDLE: in_ready=1. On accept: rf_data<=in_data, rf_go<=1 for 1 cycle, cnt<=1, go to RUN.
//   RUN: in_ready=1. On accept: rf_data<=in_data, cnt<=cnt+1. If cnt==WIN_LEN-1, the accept is
//        the last sample: rf_finish<=1 for 1 cycle, lat<=0, go to WAIT. No accept: rf_data holds.
//   WAIT: in_ready=0. lat increments each cycle. rf_finish is registered, so rf_range/rf_error are
//        sampled RF_LAT cycles after the cycle in which rf_finish is high; then go to HOLD.
//   HOLD: in_ready=0, out_valid=1, out_range/out_err are stable. On out_ready: out_valid<=0 and
//        go to IDLE. No back-to-back: the first sample of the next window is accepted at earliest
//        in the cycle after HOLD exits.
//  rf_go and rf_finish are registered outputs. They never assert in the same cycle and never
//  assert outside the sequence above.
//  abort has priority over every other transition.
//   - abort in RUN: rf_finish<=1 with rf_data held, result discarded (WAIT/HOLD skipped), go to IDLE.
//   - abort in WAIT: capture suppressed, go to IDLE.
//   - abort in HOLD: out_valid<=0, go to IDLE.
//   - abort in IDLE: ignored.
//   - abort and an accept in the same cycle: the sample is dropped, because in_ready is forced 0
//     that cycle.
//  cnt is 10 bits and never wraps, since WIN_LEN <= 1023.
//  reset mid-window: everything returns to reset values next cycle. rf_finish is not issued; the
//  range finder shares the same reset.
// STRUCTURE
//  Shared package range_pkg: WIDTH_DEF=10, typedef enum logic[1:0] {IDLE,RUN,WAIT,HOLD} rwc_state_t.
//  Single module. No sub-module beyond the external range finder instance, which my_chip connects.
// TESTING
//  1 WIN_LEN=4, samples 5,9,2,7 back-to-back, out_ready=1 -> rf_go once with 5, rf_finish once
//    with 7, out_range=7, out_err=0.
//  2 Same samples with a 3-cycle in_valid gap after 9 -> rf_data holds 9 during the gap,
//    out_range=7.
//  3 out_ready=0 for 5 cycles in HOLD -> out_valid stays 1, out_range stable, in_ready=0,
//    extra in_valid not accepted.
//  4 abort after 2 samples -> one rf_finish pulse, no out_valid, busy=0 next cycle; the next
//    window 1,1,1,1 gives out_range=0.
//  5 reset asserted in WAIT -> all outputs at reset values next cycle; the following window
//    gives a correct result.
//  6 Model rf_error=1 at capture -> out_err=1 alongside out_range.

Source files
------------

// File: rtl/range_pkg.sv
// Shared definitions for the range-finder window sequencer.
package range_pkg;

  localparam int WIDTH_DEF = 10;
  localparam int CNT_W     = 10;
  localparam int LAT_W     = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } rwc_state_t;

endpackage

// File: rtl/range_window_ctrl.sv
// Cuts a valid/ready sample stream into fixed windows of WIN_LEN samples,
// sequences one range-finder pass per window (go / data / finish) and
// presents the captured range and error flag on a valid/ready result port.
module range_window_ctrl
  import range_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int WIN_LEN = 8,
  parameter int RF_LAT  = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             abort,
  output logic [WIDTH-1:0] rf_data,
  output logic             rf_go,
  output logic             rf_finish,
  input  logic [WIDTH-1:0] rf_range,
  input  logic             rf_error,
  output logic [WIDTH-1:0] out_range,
  output logic             out_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  // Count value at which the next accept closes the window.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIN_LEN - 1);
  // Cycles after the rf_finish cycle at which the range finder result is valid.
  localparam logic [LAT_W-1:0] LAT_TGT  = LAT_W'(RF_LAT);

  rwc_state_t       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [LAT_W-1:0] lat, lat_n;
  logic [WIDTH-1:0] rf_data_n;
  logic             rf_go_n;
  logic             rf_finish_n;
  logic [WIDTH-1:0] out_range_n;
  logic             out_err_n;
  logic             out_valid_n;
  logic             accept;

  // Samples are taken only while a window is open; abort forces ready low
  // so a sample offered in the abort cycle is dropped.
  assign in_ready = ((state == IDLE) || (state == RUN)) && !abort;
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);

  // Next-state and next-output logic for the window sequencer.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    lat_n       = lat;
    rf_data_n   = rf_data;
    rf_go_n     = 1'b0;
    rf_finish_n = 1'b0;
    out_range_n = out_range;
    out_err_n   = out_err;
    out_valid_n = out_valid;

    case (state)
      IDLE: begin
        // abort here has no effect beyond masking in_ready.
        if (accept) begin
          rf_data_n = in_data;
          rf_go_n   = 1'b1;
          cnt_n     = CNT_W'(1);
          state_n   = RUN;
        end
      end

      RUN: begin
        if (abort) begin
          // Close the pass cleanly on the held sample; the result is discarded.
          rf_finish_n = 1'b1;
          cnt_n       = '0;
          state_n     = IDLE;
        end else if (accept) begin
          rf_data_n = in_data;
          cnt_n     = cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            rf_finish_n = 1'b1;
            lat_n       = '0;
            state_n     = WAIT;
          end
        end
        // Without an accept rf_data holds: a repeated sample leaves max-min unchanged.
      end

      WAIT: begin
        if (abort) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else if (lat == LAT_TGT) begin
          out_range_n = rf_range;
          out_err_n   = rf_error;
          out_valid_n = 1'b1;
          state_n     = HOLD;
        end else begin
          lat_n = lat + LAT_W'(1);
        end
      end

      HOLD: begin
        if (abort || out_ready) begin
          out_valid_n = 1'b0;
          cnt_n       = '0;
          state_n     = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset returns every output to zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      lat       <= '0;
      rf_data   <= '0;
      rf_go     <= 1'b0;
      rf_finish <= 1'b0;
      out_range <= '0;
      out_err   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      lat       <= lat_n;
      rf_data   <= rf_data_n;
      rf_go     <= rf_go_n;
      rf_finish <= rf_finish_n;
      out_range <= out_range_n;
      out_err   <= out_err_n;
      out_valid <= out_valid_n;
    end
  end

endmodule

// File: tb/tb_range_window_ctrl.sv
// Bench for range_window_ctrl: behavioural range-finder model, window-level
// reference model, table-driven windows, corner sequences and random traffic.
module tb_range_window_ctrl;

  localparam int WIDTH   = 10;
  localparam int WIN_LEN = 4;
  localparam int RF_LAT  = 2;
  localparam logic [WIDTH:0] JUNK = {1'b1, {WIDTH{1'b1}}};

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             abort = 1'b0;
  logic [WIDTH-1:0] rf_data;
  logic             rf_go;
  logic             rf_finish;
  logic [WIDTH-1:0] rf_range;
  logic             rf_error;
  logic [WIDTH-1:0] out_range;
  logic             out_err;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             busy;

  always #5 clock = ~clock;

  range_window_ctrl #(.WIDTH(WIDTH), .WIN_LEN(WIN_LEN), .RF_LAT(RF_LAT)) dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .abort(abort), .rf_data(rf_data), .rf_go(rf_go),
    .rf_finish(rf_finish), .rf_range(rf_range), .rf_error(rf_error),
    .out_range(out_range), .out_err(out_err), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  function automatic logic [WIDTH-1:0] fmax(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [WIDTH-1:0] fmin(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return (a < b) ? a : b;
  endfunction

  // ---------------- external range finder model ----------------
  // Tracks min/max of rf_data from go through finish inclusive; result
  // appears RF_LAT cycles after the finish cycle and is junk otherwise.
  logic             err_cfg = 1'b0;
  logic [WIDTH:0]   pipe [RF_LAT];
  logic [WIDTH-1:0] rf_mn, rf_mx;
  logic             rf_trk;

  always @(posedge clock) begin
    if (reset) begin
      rf_trk <= 1'b0;
      for (int k = 0; k < RF_LAT; k++) pipe[k] <= JUNK;
    end else begin
      for (int k = RF_LAT - 1; k > 0; k--) pipe[k] <= pipe[k-1];
      pipe[0] <= JUNK;
      if (rf_go) begin
        rf_mn  <= rf_data;
        rf_mx  <= rf_data;
        rf_trk <= 1'b1;
      end else if (rf_trk) begin
        rf_mn <= fmin(rf_mn, rf_data);
        rf_mx <= fmax(rf_mx, rf_data);
        if (rf_finish) begin
          pipe[0] <= {err_cfg, fmax(rf_mx, rf_data) - fmin(rf_mn, rf_data)};
          rf_trk  <= 1'b0;
        end
      end
    end
  end

  assign rf_range = pipe[RF_LAT-1][WIDTH-1:0];
  assign rf_error = pipe[RF_LAT-1][WIDTH];

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Window-level reference model.
  int               m_acc = 0;       // samples accepted in the open window
  bit               m_closing = 0;   // window complete, result not yet consumed
  int               m_cd = 0;        // cycles until the result is presented
  bit               m_hold = 0;      // result on offer
  bit               m_go_n = 0, m_fin_n = 0;
  logic [WIDTH-1:0] m_last = '0, m_min = '0, m_max = '0, m_res = '0;
  logic             m_err = 1'b0;

  // Observations and event bookkeeping.
  logic             ob_ready, ob_go, ob_fin, ob_ov, ob_oe, ob_busy;
  logic [WIDTH-1:0] ob_rfdata, ob_or;
  int               go_cnt = 0, fin_cnt = 0;
  logic [WIDTH-1:0] go_data = '0, fin_data = '0, res_range = '0;
  logic             res_err = 1'b0;
  bit               res_seen = 0, last_acc = 0;

  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic ab,
                      input logic ordy, input logic rs);
    logic exp_ready;
    logic acc;
    bit   new_go, new_fin;
    @(negedge clock);
    in_valid  = v;
    in_data   = d;
    abort     = ab;
    out_ready = ordy;
    reset     = rs;
    #1;
    ob_ready  = in_ready;  ob_go = rf_go;  ob_fin = rf_finish;  ob_rfdata = rf_data;
    ob_ov     = out_valid; ob_or = out_range; ob_oe = out_err;  ob_busy = busy;
    exp_ready = !m_closing && !ab;
    if (chk_en) begin
      check("in_ready", ob_ready, exp_ready);
      check("rf_go", ob_go, m_go_n);
      check("rf_finish", ob_fin, m_fin_n);
      check("rf_data", ob_rfdata, m_last);
      check("out_valid", ob_ov, m_hold);
      check("busy", ob_busy, (m_acc > 0) || m_closing);
      check("go_finish_overlap", ob_go & ob_fin, 0);
      if (m_hold) begin
        check("out_range", ob_or, m_res);
        check("out_err", ob_oe, m_err);
      end
    end
    if (ob_go)  begin go_cnt++;  go_data  = ob_rfdata; end
    if (ob_fin) begin fin_cnt++; fin_data = ob_rfdata; end
    if (ob_ov)  begin res_seen = 1; res_range = ob_or; res_err = ob_oe; end

    acc      = v && exp_ready && !rs;
    last_acc = acc;
    new_go   = 0;
    new_fin  = 0;
    if (rs) begin
      m_acc = 0; m_closing = 0; m_cd = 0; m_hold = 0; m_last = '0;
    end else if (ab) begin
      if (m_acc > 0) new_fin = 1;
      m_acc = 0; m_closing = 0; m_cd = 0; m_hold = 0;
    end else begin
      if (m_hold && ordy) begin m_hold = 0; m_closing = 0; end
      if (m_cd > 0) begin
        m_cd--;
        if (m_cd == 0) m_hold = 1;
      end
      if (acc) begin
        m_last = d;
        if (m_acc == 0) begin new_go = 1; m_min = d; m_max = d; end
        else begin m_min = fmin(m_min, d); m_max = fmax(m_max, d); end
        m_acc++;
        if (m_acc == WIN_LEN) begin
          new_fin   = 1;
          m_acc     = 0;
          m_closing = 1;
          m_cd      = RF_LAT + 1;
          m_res     = m_max - m_min;
          m_err     = err_cfg;
        end
      end
    end
    m_go_n  = new_go;
    m_fin_n = new_fin;
  endtask

  task automatic feed(input logic [WIDTH-1:0] d);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, d, 1'b0, 1'b1, 1'b0);
      if (last_acc) break;
    end
    check("feed_accepted", last_acc, 1);
  endtask

  task automatic wait_result(input logic ordy);
    res_seen = 0;
    for (int i = 0; i < 30 && !res_seen; i++) step(1'b0, '0, 1'b0, ordy, 1'b0);
    check("result_seen", res_seen, 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
  endtask

  typedef struct packed {
    logic [3:0][WIDTH-1:0] s;
    logic                  err;
    logic [WIDTH-1:0]      rng;
  } vec_t;

  function automatic vec_t mk(input int a, input int b, input int c, input int d,
                              input logic e, input int r);
    vec_t t;
    t.s[0] = WIDTH'(a); t.s[1] = WIDTH'(b); t.s[2] = WIDTH'(c); t.s[3] = WIDTH'(d);
    t.err  = e;
    t.rng  = WIDTH'(r);
    return t;
  endfunction

  vec_t tbl [5];

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = mk(5, 9, 2, 7, 1'b0, 7);
    tbl[1] = mk(1, 1, 1, 1, 1'b0, 0);
    tbl[2] = mk(0, 1023, 512, 3, 1'b0, 1023);
    tbl[3] = mk(100, 50, 75, 60, 1'b1, 50);
    tbl[4] = mk(8, 8, 9, 8, 1'b1, 1);

    // Reset state
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("rst_rf_go", ob_go, 0);
    check("rst_rf_finish", ob_fin, 0);
    check("rst_rf_data", ob_rfdata, 0);
    check("rst_out_valid", ob_ov, 0);
    check("rst_out_range", ob_or, 0);
    check("rst_out_err", ob_oe, 0);
    check("rst_busy", ob_busy, 0);
    check("rst_in_ready", ob_ready, 1);

    // Table windows, back-to-back samples, result consumed at once
    for (int t = 0; t < 5; t++) begin
      err_cfg = tbl[t].err;
      go_cnt = 0; fin_cnt = 0;
      for (int j = 0; j < 4; j++) feed(tbl[t].s[j]);
      wait_result(1'b1);
      check("tbl_range", res_range, tbl[t].rng);
      check("tbl_err", res_err, tbl[t].err);
      check("tbl_go_once", go_cnt, 1);
      check("tbl_fin_once", fin_cnt, 1);
      check("tbl_go_data", go_data, tbl[t].s[0]);
      check("tbl_fin_data", fin_data, tbl[t].s[3]);
      idle(2);
    end

    // Input gap: rf_data holds the last sample
    err_cfg = 1'b0;
    feed(10'd5); feed(10'd9);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      check("gap_rf_data", ob_rfdata, 9);
    end
    feed(10'd2); feed(10'd7);
    wait_result(1'b1);
    check("gap_range", res_range, 7);
    idle(2);

    // Stalled result: held, stable, no new accepts
    feed(10'd5); feed(10'd9); feed(10'd2); feed(10'd7);
    wait_result(1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 10'd33, 1'b0, 1'b0, 1'b0);
      check("stall_out_valid", ob_ov, 1);
      check("stall_out_range", ob_or, 7);
      check("stall_in_ready", ob_ready, 0);
      check("stall_no_accept", last_acc, 0);
    end
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("post_hold_ready", ob_ready, 1);
    check("post_hold_valid", ob_ov, 0);
    idle(1);

    // Abort after two samples, sample offered with abort is dropped
    feed(10'd3); feed(10'd4);
    fin_cnt = 0; res_seen = 0;
    step(1'b1, 10'd99, 1'b1, 1'b1, 1'b0);
    check("abort_in_ready", ob_ready, 0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("abort_finish", ob_fin, 1);
    check("abort_busy", ob_busy, 0);
    check("abort_rf_data", ob_rfdata, 4);
    idle(6);
    check("abort_fin_once", fin_cnt, 1);
    check("abort_no_result", res_seen, 0);
    feed(10'd1); feed(10'd1); feed(10'd1); feed(10'd1);
    wait_result(1'b1);
    check("after_abort_range", res_range, 0);
    idle(2);

    // Reset in WAIT
    feed(10'd5); feed(10'd9); feed(10'd2); feed(10'd7);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("rstw_rf_go", ob_go, 0);
    check("rstw_rf_finish", ob_fin, 0);
    check("rstw_rf_data", ob_rfdata, 0);
    check("rstw_out_valid", ob_ov, 0);
    check("rstw_out_range", ob_or, 0);
    check("rstw_busy", ob_busy, 0);
    feed(10'd4); feed(10'd6); feed(10'd1); feed(10'd3);
    wait_result(1'b1);
    check("rstw_next_range", res_range, 5);
    idle(2);

    // Error flag captured alongside the range
    err_cfg = 1'b1;
    feed(10'd20); feed(10'd30); feed(10'd25); feed(10'd10);
    wait_result(1'b1);
    check("err_range", res_range, 20);
    check("err_flag", res_err, 1);
    idle(2);

    // Random traffic against the reference model
    for (int i = 0; i < 1500; i++) begin
      logic             v, ab, ordy, rs;
      logic [WIDTH-1:0] d;
      if (m_acc == 0 && !m_closing) err_cfg = 1'($urandom % 2);
      v    = ($urandom % 4) != 0;
      d    = WIDTH'($urandom % 1001);
      ab   = ($urandom % 40) == 0;
      ordy = ($urandom % 3) != 0;
      rs   = ($urandom % 500) == 0;
      step(v, d, ab, ordy, rs);
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
